// File: rtl/mem_conflict_arbiter.sv
// mem_conflict_arbiter
//
// Request-side arbiter in front of the dual-port data memory. Master m0 is
// wired to memory port A and master m1 to memory port B. Both masters pass
// straight through unless they hit the same memory word in the same cycle
// with at least one of them writing. In that case only the master selected
// by the priority bit is forwarded, and the loser is held off for the cycle.
// The priority bit then moves to the loser, so no master is refused twice in
// a row. Responses are forwarded only on ports that actually issued a request
// in the previous cycle.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   m0_* / m1_*                  OBI-style master request and response
//                                (req, addr, we, be, wdata / gnt, rvalid,
//                                err, rdata)
//   mem_a_* / mem_b_*            memory port A (from m0) / port B (from m1)
//   conflict_cnt                 saturating count of resolved conflicts
module mem_conflict_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int M_ADDR_WIDTH = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic                    m0_err,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic                    m1_err,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic                    mem_a_req,
    output logic [ADDR_WIDTH-1:0]   mem_a_addr,
    output logic                    mem_a_we,
    output logic [DATA_WIDTH/8-1:0] mem_a_be,
    output logic [DATA_WIDTH-1:0]   mem_a_wdata,
    input  logic                    mem_a_gnt,
    input  logic                    mem_a_rvalid,
    input  logic                    mem_a_err,
    input  logic [DATA_WIDTH-1:0]   mem_a_rdata,

    output logic                    mem_b_req,
    output logic [ADDR_WIDTH-1:0]   mem_b_addr,
    output logic                    mem_b_we,
    output logic [DATA_WIDTH/8-1:0] mem_b_be,
    output logic [DATA_WIDTH-1:0]   mem_b_wdata,
    input  logic                    mem_b_gnt,
    input  logic                    mem_b_rvalid,
    input  logic                    mem_b_err,
    input  logic [DATA_WIDTH-1:0]   mem_b_rdata,

    output logic [CNT_WIDTH-1:0]    conflict_cnt
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;

    // Word index used for the collision compare; byte offset bits are
    // dropped so that e.g. 0x10 and 0x11 are recognised as the same word.
    logic [M_ADDR_WIDTH-1:0] widx_0;
    logic [M_ADDR_WIDTH-1:0] widx_1;

    logic                 conflict;
    logic                 prio_reg;
    logic                 prio_next;
    logic                 issued_a_reg;
    logic                 issued_a_next;
    logic                 issued_b_reg;
    logic                 issued_b_next;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;

    assign widx_0 = m0_addr[M_ADDR_WIDTH+OFF_W-1:OFF_W];
    assign widx_1 = m1_addr[M_ADDR_WIDTH+OFF_W-1:OFF_W];

    // Read/read to the same word is harmless on a dual-port RAM; only a
    // write on either side makes the pair hazardous.
    assign conflict = m0_req & m1_req & (widx_0 == widx_1) & (m0_we | m1_we);

    // prio_reg = 0 lets m0 win a conflict, prio_reg = 1 lets m1 win.
    assign mem_a_req   = m0_req & ~(conflict &  prio_reg);
    assign mem_b_req   = m1_req & ~(conflict & ~prio_reg);

    assign mem_a_addr  = m0_addr;
    assign mem_a_we    = m0_we;
    assign mem_a_be    = m0_be;
    assign mem_a_wdata = m0_wdata;

    assign mem_b_addr  = m1_addr;
    assign mem_b_we    = m1_we;
    assign mem_b_be    = m1_be;
    assign mem_b_wdata = m1_wdata;

    assign m0_gnt = mem_a_req & mem_a_gnt;
    assign m1_gnt = mem_b_req & mem_b_gnt;

    // A response is only routed back when this port issued last cycle, so a
    // stray memory rvalid (e.g. for a request accepted during reset) is
    // swallowed.
    assign m0_rvalid = mem_a_rvalid & issued_a_reg;
    assign m0_err    = mem_a_err;
    assign m0_rdata  = mem_a_rdata;

    assign m1_rvalid = mem_b_rvalid & issued_b_reg;
    assign m1_err    = mem_b_err;
    assign m1_rdata  = mem_b_rdata;

    assign conflict_cnt = cnt_reg;

    always_comb begin
        prio_next     = prio_reg;
        issued_a_next = mem_a_req & mem_a_gnt;
        issued_b_next = mem_b_req & mem_b_gnt;
        cnt_next      = cnt_reg;
        if (conflict) begin
            // The loser owns the next conflict. Its index is the inverse of
            // the current winner's.
            prio_next = ~prio_reg;
            if (cnt_reg != {CNT_WIDTH{1'b1}}) begin
                cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg     <= 1'b0;
            issued_a_reg <= 1'b0;
            issued_b_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            prio_reg     <= prio_next;
            issued_a_reg <= issued_a_next;
            issued_b_reg <= issued_b_next;
            cnt_reg      <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mem_conflict_arbiter.sv
module tb_mem_conflict_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MAW = 16;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    logic          m0_req, m1_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_we, m1_we;
    logic [3:0]    m0_be, m1_be;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;

    logic          mem_a_req, mem_b_req, mem_a_we, mem_b_we;
    logic [AW-1:0] mem_a_addr, mem_b_addr;
    logic [3:0]    mem_a_be, mem_b_be;
    logic [DW-1:0] mem_a_wdata, mem_b_wdata;
    logic          mem_a_gnt, mem_b_gnt, mem_a_rvalid, mem_b_rvalid;
    logic          mem_a_err, mem_b_err;
    logic [DW-1:0] mem_a_rdata, mem_b_rdata;
    logic [CW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    mem_conflict_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .M_ADDR_WIDTH(MAW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_a_req(mem_a_req), .mem_a_addr(mem_a_addr), .mem_a_we(mem_a_we),
        .mem_a_be(mem_a_be), .mem_a_wdata(mem_a_wdata), .mem_a_gnt(mem_a_gnt),
        .mem_a_rvalid(mem_a_rvalid), .mem_a_err(mem_a_err), .mem_a_rdata(mem_a_rdata),
        .mem_b_req(mem_b_req), .mem_b_addr(mem_b_addr), .mem_b_we(mem_b_we),
        .mem_b_be(mem_b_be), .mem_b_wdata(mem_b_wdata), .mem_b_gnt(mem_b_gnt),
        .mem_b_rvalid(mem_b_rvalid), .mem_b_err(mem_b_err), .mem_b_rdata(mem_b_rdata),
        .conflict_cnt(conflict_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural reference: who should win, what the fairness token is,
    // how many conflicts have been seen, and which port owes a response.
    int prio_m = 0;
    int cnt_m  = 0;
    bit iss_m0 = 1'b0, iss_m1 = 1'b0;

    // Memory environment (does not reset, like a real RAM wrapper).
    logic [DW-1:0] ram [0:65535];
    bit            pend_v0 = 1'b0, pend_v1 = 1'b0;
    logic [DW-1:0] pend_d0, pend_d1;
    bit            pend_e0, pend_e1;
    bit            rand_env = 1'b0;

    // Values observed in the most recent cycle, for directed checks.
    logic o_gnt0, o_gnt1, o_rv0, o_rv1;
    logic [DW-1:0] o_rd0, o_rd1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] widx(input logic [AW-1:0] a);
        return 16'((a >> 2) & 32'hFFFF);
    endfunction

    task automatic wr_ram(input logic [15:0] w, input logic [3:0] be, input logic [DW-1:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) ram[w][8*b +: 8] = d[8*b +: 8];
    endtask

    // One clock cycle: inputs are already set by the caller (posedge+1).
    task automatic do_cycle();
        bit conf, ok0, ok1, eg0, eg1, erv0, erv1, act0, act1;
        logic [15:0] wa, wb;
        mem_a_rvalid = pend_v0 | (rand_env && ($urandom_range(0, 9) == 0));
        mem_b_rvalid = pend_v1 | (rand_env && ($urandom_range(0, 9) == 0));
        mem_a_rdata  = pend_v0 ? pend_d0 : $urandom;
        mem_b_rdata  = pend_v1 ? pend_d1 : $urandom;
        mem_a_err    = pend_v0 ? pend_e0 : 1'($urandom);
        mem_b_err    = pend_v1 ? pend_e1 : 1'($urandom);
        @(negedge clk);
        conf = m0_req && m1_req && (widx(m0_addr) == widx(m1_addr)) && (m0_we || m1_we);
        ok0  = m0_req && !(conf && prio_m == 1);
        ok1  = m1_req && !(conf && prio_m == 0);
        eg0  = ok0 && mem_a_gnt;
        eg1  = ok1 && mem_b_gnt;
        erv0 = mem_a_rvalid && iss_m0;
        erv1 = mem_b_rvalid && iss_m1;
        chk("mem_a_req", 128'(mem_a_req), 128'(ok0));
        chk("mem_b_req", 128'(mem_b_req), 128'(ok1));
        chk("m0_gnt", 128'(m0_gnt), 128'(eg0));
        chk("m1_gnt", 128'(m1_gnt), 128'(eg1));
        chk("m0_rvalid", 128'(m0_rvalid), 128'(erv0));
        chk("m1_rvalid", 128'(m1_rvalid), 128'(erv1));
        chk("conflict_cnt", 128'(conflict_cnt), 128'(cnt_m));
        if (ok0) chk("mem_a_fields", {mem_a_addr, mem_a_we, mem_a_be, mem_a_wdata},
                     {m0_addr, m0_we, m0_be, m0_wdata});
        if (ok1) chk("mem_b_fields", {mem_b_addr, mem_b_we, mem_b_be, mem_b_wdata},
                     {m1_addr, m1_we, m1_be, m1_wdata});
        if (erv0) chk("m0_rdata_err", {m0_rdata, m0_err}, {pend_d0, pend_e0});
        if (erv1) chk("m1_rdata_err", {m1_rdata, m1_err}, {pend_d1, pend_e1});
        $display("t=%0t rst=%0b m0:req=%0b a=%h we=%0b gnt=%0b rv=%0b | m1:req=%0b a=%h we=%0b gnt=%0b rv=%0b | cnt=%0d",
                 $time, rst, m0_req, m0_addr, m0_we, m0_gnt, m0_rvalid,
                 m1_req, m1_addr, m1_we, m1_gnt, m1_rvalid, conflict_cnt);
        o_gnt0 = m0_gnt; o_gnt1 = m1_gnt; o_rv0 = m0_rvalid; o_rv1 = m1_rvalid;
        o_rd0 = m0_rdata; o_rd1 = m1_rdata;
        act0 = mem_a_req && mem_a_gnt;
        act1 = mem_b_req && mem_b_gnt;
        wa = widx(mem_a_addr);
        wb = widx(mem_b_addr);
        @(posedge clk);
        // reference model update
        if (rst) begin
            prio_m = 0; cnt_m = 0; iss_m0 = 0; iss_m1 = 0;
        end else begin
            iss_m0 = eg0; iss_m1 = eg1;
            if (conf) begin
                prio_m = 1 - prio_m;
                if (cnt_m < CNT_MAX) cnt_m++;
            end
        end
        // memory environment: reads see pre-write contents
        pend_v0 = act0; pend_v1 = act1;
        if (act0) begin pend_d0 = ram[wa]; pend_e0 = rand_env && ($urandom_range(0, 7) == 0); end
        if (act1) begin pend_d1 = ram[wb]; pend_e1 = rand_env && ($urandom_range(0, 7) == 0); end
        if (act0 && mem_a_we) wr_ram(wa, mem_a_be, mem_a_wdata);
        if (act1 && mem_b_we) wr_ram(wb, mem_b_be, mem_b_wdata);
        #1;
    endtask

    task automatic set_m0(input logic r, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        m0_req = r; m0_addr = a; m0_we = w; m0_be = 4'hF; m0_wdata = d;
    endtask

    task automatic set_m1(input logic r, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        m1_req = r; m1_addr = a; m1_we = w; m1_be = 4'hF; m1_wdata = d;
    endtask

    task automatic reset_cycle();
        rst = 1'b1; set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        do_cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 32'h5A00_0000 ^ i;
        mem_a_gnt = 1'b1; mem_b_gnt = 1'b1;
        rst = 1'b1; set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        do_cycle();
        do_cycle();
        rst = 1'b0;
        chk("reset_cnt", 128'(conflict_cnt), 128'(0));

        // distinct-word reads: both granted, both respond next cycle
        set_m0(1, 32'h100, 0, 0); set_m1(1, 32'h200, 0, 0);
        do_cycle();
        chk("rd_diff_gnt", {o_gnt0, o_gnt1}, 2'b11);
        set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        do_cycle();
        chk("rd_diff_rvalid", {o_rv0, o_rv1}, 2'b11);
        chk("rd_diff_data", {o_rd0, o_rd1}, {32'h5A00_0040, 32'h5A00_0080});
        chk("rd_diff_cnt", 128'(conflict_cnt), 128'(0));

        // write/read same word: m0 first, m1 next cycle sees written data
        reset_cycle();
        set_m0(1, 32'h104, 1, 32'hDEADBEEF); set_m1(1, 32'h104, 0, 0);
        do_cycle();
        chk("wr_rd_first", {o_gnt0, o_gnt1}, 2'b10);
        set_m0(0, 0, 0, 0);
        do_cycle();
        chk("wr_rd_second", {o_gnt1, o_rv0}, 2'b11);
        set_m1(0, 0, 0, 0);
        do_cycle();
        chk("wr_rd_rvalid", 128'(o_rv1), 128'(1));
        chk("wr_rd_data", 128'(o_rd1), 128'(32'hDEADBEEF));
        chk("wr_rd_cnt", 128'(conflict_cnt), 128'(1));
        // priority stayed with m1 across the idle cycles
        set_m0(1, 32'h104, 1, 32'h1); set_m1(1, 32'h104, 1, 32'h2);
        do_cycle();
        chk("prio_kept", {o_gnt0, o_gnt1}, 2'b01);

        // continuous writes to 0x40 from both: strict alternation from m0
        reset_cycle();
        set_m0(1, 32'h40, 1, 32'hA0); set_m1(1, 32'h40, 1, 32'hB0);
        for (int i = 0; i < 6; i++) begin
            do_cycle();
            chk("alt_gnt", {o_gnt0, o_gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        chk("alt_cnt", 128'(conflict_cnt), 128'(6));

        // read/read same word is not a conflict
        set_m0(1, 32'h10, 0, 0); set_m1(1, 32'h10, 0, 0);
        do_cycle();
        chk("rr_same_gnt", {o_gnt0, o_gnt1}, 2'b11);
        chk("rr_same_cnt", 128'(conflict_cnt), 128'(6));

        // byte offsets inside one word still collide; next word does not
        set_m0(1, 32'h10, 0, 0); set_m1(1, 32'h11, 1, 32'h77);
        do_cycle();
        chk("byte_off_conf", {o_gnt0, o_gnt1}, 2'b10);
        set_m0(0, 0, 0, 0);
        do_cycle();
        chk("byte_off_loser", 128'(o_gnt1), 128'(1));
        set_m0(1, 32'h10, 0, 0); set_m1(1, 32'h14, 1, 32'h88);
        do_cycle();
        chk("next_word_gnt", {o_gnt0, o_gnt1}, 2'b11);
        chk("next_word_cnt", 128'(conflict_cnt), 128'(7));

        // saturation
        set_m0(1, 32'h40, 1, 32'hC0); set_m1(1, 32'h40, 1, 32'hD0);
        for (int i = 0; i < 20; i++) do_cycle();
        chk("sat_cnt", 128'(conflict_cnt), 128'(CNT_MAX));

        // reset while m0 is granted: no response afterwards, state cleared
        rst = 1'b1; set_m0(1, 32'h100, 0, 0); set_m1(0, 0, 0, 0);
        do_cycle();
        rst = 1'b0; set_m0(0, 0, 0, 0);
        do_cycle();
        chk("rst_no_rvalid", 128'(o_rv0), 128'(0));
        chk("rst_cnt", 128'(conflict_cnt), 128'(0));

        // conflict during reset: reset wins, counter untouched, m0 wins next
        rst = 1'b1; set_m0(1, 32'h80, 1, 1); set_m1(1, 32'h80, 1, 2);
        do_cycle();
        rst = 1'b0;
        chk("rst_conf_cnt", 128'(conflict_cnt), 128'(0));
        do_cycle();
        chk("rst_conf_prio", {o_gnt0, o_gnt1}, 2'b10);

        // randomized OBI traffic with stalls, stray rvalids and resets
        rand_env = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!m0_req || o_gnt0)
                set_m0($urandom_range(0, 3) != 0,
                       ($urandom_range(0, 3) == 0 ? 32'h0010_0000 : 32'h0) |
                       (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
                       1'($urandom), $urandom);
            if (!m1_req || o_gnt1)
                set_m1($urandom_range(0, 3) != 0,
                       ($urandom_range(0, 3) == 0 ? 32'h0010_0000 : 32'h0) |
                       (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
                       1'($urandom), $urandom);
            if (!o_gnt0) m0_be = m0_be; else m0_be = 4'($urandom);
            if (o_gnt1) m1_be = 4'($urandom);
            mem_a_gnt = $urandom_range(0, 6) != 0;
            mem_b_gnt = $urandom_range(0, 6) != 0;
            rst = ($urandom_range(0, 99) == 0);
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
